sao_bo_apply: RTL

- Applies SAO band offsets to the deblocked reconstruction of one LCU. Consumes the per-component first-band decision from the BO predecision stage plus the four signed offsets per component.
- Streams 32 pixels per beat (Y, then U, then V) and writes corrected pixels to the SAO output buffer through a 2-stage pipeline.
- Sits between the deblocking/SAO-decision logic and the reconstructed-frame write-back.

---
 rtl/sao_bo_apply.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sao_bo_apply.sv
// SAO band-offset apply for one LCU.
// Streams Y, then U, then V beats of 32 pixels each. Every accepted beat goes
// through two register stages: stage 1 selects an offset per lane from the
// pixel band, and stage 2 adds that offset and clips the result to 8 bits.
module sao_bo_apply #(
    parameter int Y_BEATS = 128,
    parameter int C_BEATS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [14:0]  bo_first_i,
    input  logic [47:0]  bo_offset_i,
    input  logic [2:0]   bo_en_i,
    input  logic         valid_i,
    input  logic [255:0] block_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [255:0] block_o,
    output logic [1:0]   comp_o,
    output logic         done_o
);

    localparam logic [6:0] Y_LAST = 7'(Y_BEATS - 1);
    localparam logic [6:0] C_LAST = 7'(C_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_Y,
        S_RUN_U,
        S_RUN_V,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [6:0]   r_cnt;
    logic         r_flush;
    logic [14:0]  r_first;
    logic [47:0]  r_offset;
    logic [2:0]   r_en;

    logic         r_s1_valid;
    logic [1:0]   r_s1_comp;
    logic [255:0] r_s1_pix;
    logic [127:0] r_s1_off;

    logic         w_accept;
    logic [1:0]   w_comp;
    logic [4:0]   w_first_c;
    logic [15:0]  w_off_c;
    logic         w_en_c;
    logic [127:0] w_s1_off_all;
    logic [255:0] w_out_all;

    // ready_o is a registered copy of "in a RUN state", so it gates acceptance directly
    assign w_accept = valid_i && ready_o;

    // Component currently being streamed, and its latched parameters
    always_comb begin
        w_comp    = 2'd0;
        w_first_c = r_first[4:0];
        w_off_c   = r_offset[15:0];
        w_en_c    = r_en[0];
        case (r_state)
            S_RUN_U: begin
                w_comp    = 2'd1;
                w_first_c = r_first[9:5];
                w_off_c   = r_offset[31:16];
                w_en_c    = r_en[1];
            end
            S_RUN_V: begin
                w_comp    = 2'd2;
                w_first_c = r_first[14:10];
                w_off_c   = r_offset[47:32];
                w_en_c    = r_en[2];
            end
            default: ;
        endcase
    end

    // Per-lane band classification (stage 1 input) and offset add/clip (stage 2 input)
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_lane
            logic [4:0]        w_band;
            logic [4:0]        w_d;
            logic [3:0]        w_off;
            logic signed [9:0] w_sum;

            assign w_band = block_i[8*gi+3 +: 5];
            // 5-bit wrap lets a first band of 30 cover bands 30, 31, 0 and 1
            assign w_d    = w_band - w_first_c;
            assign w_off  = ((w_d < 5'd4) && w_en_c) ? w_off_c[{w_d[1:0], 2'b00} +: 4] : 4'd0;
            assign w_s1_off_all[4*gi +: 4] = w_off;

            assign w_sum = $signed({2'b00, r_s1_pix[8*gi +: 8]})
                         + $signed({{6{r_s1_off[4*gi+3]}}, r_s1_off[4*gi +: 4]});
            assign w_out_all[8*gi +: 8] = w_sum[9] ? 8'h00 : (w_sum[8] ? 8'hFF : w_sum[7:0]);
        end
    endgenerate

    // Control FSM: parameter latch, beat counting, flush and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 7'd0;
            r_flush  <= 1'b0;
            r_first  <= 15'd0;
            r_offset <= 48'd0;
            r_en     <= 3'd0;
            ready_o  <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_first  <= bo_first_i;
                        r_offset <= bo_offset_i;
                        r_en     <= bo_en_i;
                        r_cnt    <= 7'd0;
                        r_state  <= S_RUN_Y;
                        ready_o  <= 1'b1;
                    end
                end
                S_RUN_Y: begin
                    if (w_accept) begin
                        if (r_cnt == Y_LAST) begin
                            r_cnt   <= 7'd0;
                            r_state <= S_RUN_U;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                end
                S_RUN_U: begin
                    if (w_accept) begin
                        if (r_cnt == C_LAST) begin
                            r_cnt   <= 7'd0;
                            r_state <= S_RUN_V;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                end
                S_RUN_V: begin
                    if (w_accept) begin
                        if (r_cnt == C_LAST) begin
                            r_cnt   <= 7'd0;
                            r_flush <= 1'b0;
                            r_state <= S_FLUSH;
                            ready_o <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Two cycles: the last beat crosses stage 1 then stage 2
                    if (r_flush) begin
                        r_flush <= 1'b0;
                        r_state <= S_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        r_flush <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready_o <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: register pixels, selected offsets and component tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_comp  <= 2'd0;
            r_s1_pix   <= 256'd0;
            r_s1_off   <= 128'd0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_comp <= w_comp;
                r_s1_pix  <= block_i;
                r_s1_off  <= w_s1_off_all;
            end
        end
    end

    // Stage 2: register clipped pixels; comp_o only moves with a valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            block_o <= 256'd0;
            comp_o  <= 2'd0;
        end else begin
            valid_o <= r_s1_valid;
            if (r_s1_valid) begin
                block_o <= w_out_all;
                comp_o  <= r_s1_comp;
            end
        end
    end

endmodule
